// File: rtl/csla_pkg.sv
// Shared constants and helpers for the carry-select adder.
// Default geometry: 4-bit operands in 2-bit blocks.
package csla_pkg;

    localparam int CSLA_WIDTH = 4;
    localparam int CSLA_BLK   = 2;

    // Number of carry-select blocks across the operand.
    function automatic int csla_nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/carry_select_adder_rca_block.sv
// BLK-bit ripple-carry adder built from full-adder equations.
// Used as block 0 and as each half of a carry-select pair.
module rca_block
    import csla_pkg::*;
#(
    parameter int BLK = CSLA_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK:0] c;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[BLK];
    end

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout, s} <= a + b + cin.
// Macro CSLA_INPUT_REG_EN adds an input register stage (latency 2).
module carry_select_adder
    import csla_pkg::*;
#(
    parameter int WIDTH = CSLA_WIDTH,
    parameter int BLK   = CSLA_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NBLK = csla_nblk(WIDTH, BLK);

    if ((WIDTH < 1) || (BLK < 1) || ((WIDTH % BLK) != 0)) begin : g_bad_geom
        $error("carry_select_adder: WIDTH must be a positive multiple of BLK");
    end

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_valid;

`ifdef CSLA_INPUT_REG_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             in_valid_q, in_valid_d;

    // Capture operands every cycle; the valid bit travels with them.
    always_comb begin
        a_d        = a;
        b_d        = b;
        cin_d      = cin;
        in_valid_d = in_valid;
    end

    // Input stage register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            in_valid_q <= in_valid_d;
        end
    end

    assign op_a     = a_q;
    assign op_b     = b_q;
    assign op_cin   = cin_q;
    assign op_valid = in_valid_q;
`else
    assign op_a     = a;
    assign op_b     = b;
    assign op_cin   = cin;
    assign op_valid = in_valid;
`endif

    logic [NBLK-1:0][BLK-1:0] s0_blk;
    logic [NBLK-1:0][BLK-1:0] s1_blk;
    logic [NBLK-1:0]          c0_blk;
    logic [NBLK-1:0]          c1_blk;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_rca0
            rca_block #(.BLK(BLK)) u_rca (
                .a  (op_a[0 +: BLK]),
                .b  (op_b[0 +: BLK]),
                .ci (op_cin),
                .s  (s0_blk[0]),
                .co (c0_blk[0])
            );
            // Block 0 already saw the real carry-in; both mux legs agree.
            assign s1_blk[0] = s0_blk[0];
            assign c1_blk[0] = c0_blk[0];
        end else begin : g_sel
            rca_block #(.BLK(BLK)) u_rca_c0 (
                .a  (op_a[k*BLK +: BLK]),
                .b  (op_b[k*BLK +: BLK]),
                .ci (1'b0),
                .s  (s0_blk[k]),
                .co (c0_blk[k])
            );
            rca_block #(.BLK(BLK)) u_rca_c1 (
                .a  (op_a[k*BLK +: BLK]),
                .b  (op_b[k*BLK +: BLK]),
                .ci (1'b1),
                .s  (s1_blk[k]),
                .co (c1_blk[k])
            );
        end
    end

    logic [NBLK:0]            carry;
    logic [NBLK-1:0][BLK-1:0] s_sel;
    logic [WIDTH-1:0]         s_c;
    logic                     cout_c;

    // Carry chain: each block's precomputed pair is picked by the carry below.
    always_comb begin
        carry    = '0;
        s_sel    = '0;
        carry[0] = op_cin;
        for (int k = 0; k < NBLK; k++) begin
            s_sel[k]   = carry[k] ? s1_blk[k] : s0_blk[k];
            carry[k+1] = carry[k] ? c1_blk[k] : c0_blk[k];
        end
    end

    assign s_c    = s_sel;
    assign cout_c = carry[NBLK];

    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;

    // Load a new result only on valid; idle cycles hold it and block X.
    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        valid_d = op_valid;
        if (op_valid) begin
            s_d    = s_c;
            cout_d = cout_c;
        end
    end

    // Output result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Randomised and directed bench for carry_select_adder.
// Reference is plain integer addition through a latency queue.
module tb_carry_select_adder;

    localparam int W = 4;
`ifdef CSLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] s;
    logic         cout;

    carry_select_adder #(.WIDTH(W), .BLK(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    typedef struct {
        bit      v;
        int      sum;
    } txn_t;

    txn_t pipe[$];
    bit   exp_v;
    int   exp_sum;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        exp_v   = 1'b0;
        exp_sum = 0;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".s"}, 32'(s), 32'(exp_sum % (1 << W)));
        chk({tag, ".cout"}, 32'(cout), 32'(exp_sum >> W));
        chk({tag, ".valid"}, 32'(out_valid), 32'(exp_v));
    endtask

    // Apply one cycle of input, advance the model, check after the edge.
    task automatic step(input string tag, input int va, input int vb,
                        input int vc, input bit v);
        txn_t t;
        in_valid = v;
        if (v) begin
            a   = W'(va);
            b   = W'(vb);
            cin = vc[0];
        end else begin
            a   = 'x;
            b   = 'x;
            cin = 1'bx;
        end
        t.v   = v;
        t.sum = v ? (va + vb + vc) : 0;
        @(posedge clk);
        pipe.push_back(t);
        if (pipe.size() >= LAT) begin
            t = pipe.pop_front();
            exp_v = t.v;
            if (t.v) exp_sum = t.sum;
        end
        #1;
        check_out(tag);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'hF;
        cin      = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_out("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("reset_release");

        step("basic", 3, 5, 0, 1'b1);
        step("blk_c0", 3, 1, 0, 1'b1);
        step("blk_c1", 3, 1, 1, 1'b1);
        step("wrap_ff", 15, 15, 1, 1'b1);
        step("wrap_f0", 15, 0, 1, 1'b1);
        for (int i = 0; i < LAT; i++) step("drain", 0, 0, 0, 1'b0);

        step("hold_in", 9, 9, 0, 1'b1);
        for (int i = 0; i < 3 + LAT - 1; i++) step("hold_idle", 0, 0, 0, 1'b0);

        for (int x = 0; x < 512; x++)
            step("exh", x & 15, (x >> 4) & 15, (x >> 8) & 1, 1'b1);
        for (int i = 0; i < LAT; i++) step("exh_drain", 0, 0, 0, 1'b0);

        for (int i = 0; i < 300; i++)
            step("rnd", int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(1)), bit'($urandom_range(3) != 0));

        step("mid_a", 15, 15, 1, 1'b1);
        step("mid_b", 7, 12, 0, 1'b1);
        in_valid = 1'b1;
        a = 4'hA;
        b = 4'h9;
        cin = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_out("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("mid_reset_release");
        step("post_reset", 6, 7, 1, 1'b1);
        for (int i = 0; i < LAT; i++) step("post_drain", 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- Parameterised carry-select adder: computes a + b + cin and registers the sum and carry-out.
- Sits in datapath arithmetic as a drop-in registered adder with a valid qualifier.
- Operand is split into equal blocks. Block 0 is a plain ripple-carry adder. Each higher block computes both carry-in=0 and carry-in=1 results in parallel, and a mux selects one using the previous block's carry.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be ≥1.
- BLK, 2, bits per carry-select block; WIDTH must be an integer multiple of BLK, checked by an elaboration-time assertion.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry in
- out_valid  output  1  s/cout hold a new result
- s  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH
- cout  output  1  registered carry out, bit WIDTH of a+b+cin

Behaviour:
- Reset: while rst_n=0, s, cout and out_valid are 0 immediately (asynchronously). On release, outputs stay 0 until the next capturing edge.
- Datapath:
  - Combinational {cout_c, s_c} = a + b + cin, full WIDTH+1-bit result, no overflow flag.
  - Block 0 ripples from cin.
  - Block k>0 has two ripple adders (carry 0, carry 1); the select is block k-1's carry-out; the last block's selected carry is cout.
- Latency: 1 cycle. On each rising clk edge:
  - out_valid <= in_valid.
  - If in_valid=1, s <= s_c and cout <= cout_c.
  - If in_valid=0, s and cout hold their previous values.
- No backpressure: a result is produced for every valid input, and back-to-back valid inputs give back-to-back results.
- Wrap-around: a=2^WIDTH-1, b=2^WIDTH-1, cin=1 gives s=2^WIDTH-1, cout=1. Any sum ≥ 2^WIDTH sets cout=1 and s = sum - 2^WIDTH.
- Reset asserted mid-stream clears s, cout and out_valid at once; the in-flight result is discarded.
- X on a, b or cin while in_valid=0 must not propagate to s or cout.
- Result must be bit-identical to the behavioural a+b+cin for all 2^(2*WIDTH+1) input combinations.

Optional Feature:
- Macro CSLA_INPUT_REG_EN.
- Defined:
  - a, b, cin and in_valid are first captured in an input register stage, which resets to 0 on rst_n=0.
  - The adder operates on the registered values.
  - Latency becomes 2 cycles (in_valid to out_valid); all other rules are unchanged.
- Undefined: latency is 1 cycle as described above.

Decomposition:
- Package csla_pkg:
  - Default constants CSLA_WIDTH=4 and CSLA_BLK=2.
  - A function computing the number of blocks (WIDTH/BLK).
- Sub-module rca_block: BLK-bit ripple-carry adder (ports a, b, ci, s, co) built from full-adder equations.
  - Instantiated once for block 0.
  - Instantiated twice (ci tied to 0 and to 1) per higher block.
- Top-level holds the select muxes, the carry chain, the output registers and the optional input registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=4'hF, b=4'hF -> s=0, cout=0, out_valid=0. Assert rst_n=0 mid-stream -> outputs clear without waiting for a clock edge.
- Basic: a=4'd3, b=4'd5, cin=0, in_valid=1 -> one edge later s=4'd8, cout=0, out_valid=1.
- Carry across block boundary: a=4'b0011, b=4'b0001, cin=0 -> s=4'b0100, cout=0. Same a, b with cin=1 -> s=4'b0101.
- Wrap: a=4'hF, b=4'hF, cin=1 -> s=4'hF, cout=1. a=4'hF, b=4'h0, cin=1 -> s=4'h0, cout=1.
- Exhaustive: all 512 combinations of a(0..15), b(0..15), cin(0..1), back-to-back with in_valid=1 -> each {cout,s} equals a+b+cin one cycle after its input (two cycles with CSLA_INPUT_REG_EN).
- Hold: in_valid=0 for 3 cycles after a=9, b=9, cin=0 -> s=4'd2, cout=1 hold, out_valid=0 after the first idle edge.
